// File: rtl/alu_pkg.sv
// Operation codes shared by the ALU control decoder and the execute-stage ALU,
// so the two blocks cannot disagree on an encoding.
package alu_pkg;

  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_AND = 4'd0,
    ALU_OR  = 4'd1,
    ALU_ADD = 4'd2,
    ALU_SLL = 4'd3,
    ALU_SRL = 4'd4,
    ALU_SUB = 4'd6,
    ALU_SLT = 4'd7,
    ALU_MUL = 4'd8
  } alu_op_e;

endpackage

// File: rtl/alu_multicycle_mul_shift_add.sv
// Iterative shift-add multiplier: one partial product per step, low DATA_W bits
// of the product only, fixed DATA_W steps per operation.
module mul_shift_add #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  output logic [DATA_W-1:0] acc_next,
  output logic              last
);

  logic [DATA_W-1:0] mcand_q;
  logic [DATA_W-1:0] mplier_q;
  logic [DATA_W-1:0] acc_q;
  logic [CNT_W-1:0]  count_q;

  // acc_next is the accumulator after the current step, so the parent can
  // capture the final product on the last step without an extra cycle.
  assign acc_next = mplier_q[0] ? acc_q + mcand_q : acc_q;
  assign last     = (count_q == CNT_W'(DATA_W - 1));

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
    end else if (load) begin
      mcand_q  <= operand_a;
      mplier_q <= operand_b;
      acc_q    <= '0;
      count_q  <= '0;
    end else if (step) begin
      acc_q    <= acc_next;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      count_q  <= count_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Execute-stage ALU: single-cycle ops register their result on the issue edge;
// MUL stalls the pipeline (busy) for DATA_W cycles on the shift-add multiplier.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = $clog2(DATA_W)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ALU_OP_W-1:0] alu_control,
  input  logic [DATA_W-1:0]   operand_a,
  input  logic [DATA_W-1:0]   operand_b,
  output logic [DATA_W-1:0]   result,
  output logic                zero,
  output logic                done,
  output logic                busy
);

  typedef enum logic {S_IDLE, S_MUL} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              zero_q;
  logic              done_q, done_d;
  logic [DATA_W-1:0] alu_out;
  logic [DATA_W-1:0] mul_acc_next;
  logic              mul_load, mul_step, mul_last;
  logic              issue_mul;

  assign issue_mul = start && (alu_control == ALU_MUL);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    alu_out = '0;
    case (alu_control)
      ALU_AND: alu_out = operand_a & operand_b;
      ALU_OR:  alu_out = operand_a | operand_b;
      ALU_ADD: alu_out = operand_a + operand_b;
      ALU_SUB: alu_out = operand_a - operand_b;
      ALU_SLL: alu_out = operand_a << operand_b[SHAMT_W-1:0];
      ALU_SRL: alu_out = operand_a >> operand_b[SHAMT_W-1:0];
      ALU_SLT: alu_out = {{(DATA_W-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
      default: alu_out = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (issue_mul) state_d = S_MUL;
      S_MUL:   if (mul_last)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // start is only looked at in IDLE, so requests during a MUL are dropped.
  always_comb begin
    result_d = result_q;
    done_d   = 1'b0;
    mul_load = 1'b0;
    mul_step = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (issue_mul) begin
          mul_load = 1'b1;
        end else if (start) begin
          result_d = alu_out;
          done_d   = 1'b1;
        end
      end
      S_MUL: begin
        mul_step = 1'b1;
        if (mul_last) begin
          result_d = mul_acc_next;
          done_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      zero_q   <= (result_d == '0);
      done_q   <= done_d;
    end
  end

  mul_shift_add #(.DATA_W(DATA_W)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .load      (mul_load),
    .step      (mul_step),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .acc_next  (mul_acc_next),
    .last      (mul_last)
  );

  assign result = result_q;
  assign zero   = zero_q;
  assign done   = done_q;
  assign busy   = (state_q == S_MUL);

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle: a vector table for single-cycle ops plus
// hand-written sequences around MUL stalls, back-to-back issue and reset.
module tb_alu_multicycle;
  import alu_pkg::*;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [3:0]    alu_control;
  logic [W-1:0]  operand_a, operand_b;
  logic [W-1:0]  result;
  logic          zero, done, busy;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         z;
  } vec_t;

  localparam int N_VECS = 13;
  vec_t vecs [N_VECS];

  alu_multicycle #(.DATA_W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .alu_control (alu_control),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .result      (result),
    .zero        (zero),
    .done        (done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    start       = 1'b1;
    alu_control = op;
    operand_a   = a;
    operand_b   = b;
  endtask

  // Issues a MUL, checks the busy window edge by edge, then the completion.
  // With inject set, an ADD with fresh operands is driven mid-multiply.
  task automatic run_mul(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp, input bit inject);
    int bad;
    bad = 0;
    issue(ALU_MUL, a, b);
    tick();
    start = 1'b0;
    check({name, "_busy_rise"}, W'(busy), W'(1));
    check({name, "_no_early_done"}, W'(done), W'(0));
    for (int i = 1; i < W; i++) begin
      if (inject && i == 5) issue(ALU_ADD, 32'd100, 32'd200);
      if (inject && i == 7) start = 1'b0;
      tick();
      if (busy !== 1'b1 || done !== 1'b0) bad++;
    end
    check({name, "_busy_window_errs"}, W'(bad), W'(0));
    tick();
    check({name, "_result"}, result, exp);
    check({name, "_zero"}, W'(zero), W'(exp == '0));
    check({name, "_done"}, W'(done), W'(1));
    check({name, "_busy_fall"}, W'(busy), W'(0));
  endtask

  initial begin
    vecs[0]  = '{ALU_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1};
    vecs[1]  = '{ALU_SUB, 32'd5,         32'd7,         32'hFFFF_FFFE, 1'b0};
    vecs[2]  = '{ALU_SLT, 32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0};
    vecs[3]  = '{ALU_SLT, 32'd1,         32'hFFFF_FFFF, 32'd0,         1'b1};
    vecs[4]  = '{ALU_SLT, 32'd5,         32'd7,         32'd1,         1'b0};
    vecs[5]  = '{ALU_SRL, 32'h8000_0000, 32'd31,        32'd1,         1'b0};
    vecs[6]  = '{ALU_SRL, 32'h8000_0000, 32'h20,        32'h8000_0000, 1'b0};
    vecs[7]  = '{ALU_SLL, 32'd1,         32'h21,        32'd2,         1'b0};
    vecs[8]  = '{ALU_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0};
    vecs[9]  = '{ALU_OR,  32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0};
    vecs[10] = '{4'd5,    32'hDEAD_BEEF, 32'h1234_5678, 32'd0,         1'b1};
    vecs[11] = '{4'd12,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         1'b1};
    vecs[12] = '{4'd15,   32'd9,         32'd9,         32'd0,         1'b1};

    rst = 1'b1;
    start = 1'b0;
    alu_control = '0;
    operand_a = '0;
    operand_b = '0;
    tick();
    tick();
    check("reset_result", result, 32'd0);
    check("reset_zero", W'(zero), W'(1));
    check("reset_done", W'(done), W'(0));
    check("reset_busy", W'(busy), W'(0));
    rst = 1'b0;
    tick();

    for (int i = 0; i < N_VECS; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      tick();
      start = 1'b0;
      check($sformatf("vec%0d_result", i), result, vecs[i].res);
      check($sformatf("vec%0d_zero", i), W'(zero), W'(vecs[i].z));
      check($sformatf("vec%0d_done", i), W'(done), W'(1));
      tick();
      check($sformatf("vec%0d_done_fall", i), W'(done), W'(0));
      check($sformatf("vec%0d_hold", i), result, vecs[i].res);
    end

    // Back-to-back single-cycle ops: done stays high, result updates each cycle.
    issue(ALU_ADD, 32'd1, 32'd1);
    tick();
    check("b2b_0_result", result, 32'd2);
    check("b2b_0_done", W'(done), W'(1));
    issue(ALU_SUB, 32'd10, 32'd3);
    tick();
    check("b2b_1_result", result, 32'd7);
    check("b2b_1_done", W'(done), W'(1));
    issue(ALU_SUB, 32'd3, 32'd3);
    tick();
    start = 1'b0;
    check("b2b_2_result", result, 32'd0);
    check("b2b_2_zero", W'(zero), W'(1));
    check("b2b_2_done", W'(done), W'(1));
    tick();
    check("b2b_done_fall", W'(done), W'(0));

    // MUL with an ignored ADD during the stall; done must pulse exactly once.
    run_mul("mul_7x6", 32'd7, 32'd6, 32'd42, 1'b1);
    tick();
    check("mul_7x6_single_done", W'(done), W'(0));
    check("mul_7x6_hold", result, 32'd42);
    check("mul_7x6_idle", W'(busy), W'(0));

    run_mul("mul_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0);
    tick();
    run_mul("mul_zero", 32'd0, 32'h0001_2345, 32'd0, 1'b0);
    tick();

    // ADD issued in the MUL done cycle is accepted immediately.
    run_mul("mul_wrap", 32'h1234_5678, 32'd16, 32'h2345_6780, 1'b0);
    issue(ALU_ADD, 32'd3, 32'd4);
    tick();
    start = 1'b0;
    check("done_cycle_add_result", result, 32'd7);
    check("done_cycle_add_done", W'(done), W'(1));
    check("done_cycle_add_busy", W'(busy), W'(0));
    tick();

    // Reset sampled at the tenth iteration edge of a MUL.
    begin
      int stray_done;
      stray_done = 0;
      issue(ALU_MUL, 32'd7, 32'd6);
      tick();
      start = 1'b0;
      for (int i = 1; i < 10; i++) tick();
      rst = 1'b1;
      tick();
      check("rst_mul_result", result, 32'd0);
      check("rst_mul_zero", W'(zero), W'(1));
      check("rst_mul_done", W'(done), W'(0));
      check("rst_mul_busy", W'(busy), W'(0));
      rst = 1'b0;
      for (int i = 0; i < W + 4; i++) begin
        tick();
        if (done !== 1'b0 || busy !== 1'b0) stray_done++;
      end
      check("rst_mul_no_late_done", W'(stray_done), W'(0));
    end
    issue(ALU_ADD, 32'd20, 32'd22);
    tick();
    start = 1'b0;
    check("post_rst_add_result", result, 32'd42);
    check("post_rst_add_done", W'(done), W'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
